// File: rtl/phase_tracker.sv
// Recovers a binary phase index from a rotating one-hot phase vector, locks onto
// the rotation, flywheels through glitches while locked and counts mismatches.
module phase_tracker #(
    parameter int PHASES     = 2,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_LIMIT  = 2,
    localparam int IDXW      = (PHASES > 2) ? $clog2(PHASES) : 1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [PHASES-1:0] phaseIn,
    input  logic              clrErr,
    output logic [IDXW-1:0]   phaseIdx,
    output logic              phaseValid,
    output logic              locked,
    output logic              phaseErr,
    output logic [7:0]        errCount
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [MW-1:0]   match_q, match_d;
    logic [EW-1:0]   miss_q, miss_d;

    logic            one_hot;
    logic [IDXW-1:0] hot_idx;
    logic            bad;
    logic [7:0]      cnt_base;

    // The rotation moves the set bit downward, wrapping 0 -> PHASES-1.
    function automatic logic [IDXW-1:0] succ(input logic [IDXW-1:0] i);
        return (i == '0) ? IDXW'(PHASES - 1) : i - 1'b1;
    endfunction

    always_comb begin
        one_hot = (phaseIn != '0) && ((phaseIn & (phaseIn - 1'b1)) == '0);
        hot_idx = '0;
        for (int i = 0; i < PHASES; i++) begin
            if (phaseIn[i]) hot_idx = IDXW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        match_d = match_q;
        miss_d  = miss_q;
        valid_d = one_hot;
        err_d   = 1'b0;
        bad     = 1'b0;
        case (state_q)
            SEARCH: begin
                if (!one_hot) begin
                    match_d = '0;
                end else begin
                    idx_d = hot_idx;
                    if (valid_q && (hot_idx == succ(idx_q))) match_d = match_q + 1'b1;
                    else match_d = MW'(1);
                    if (match_d == MW'(LOCK_COUNT)) begin
                        state_d = LOCKED;
                        miss_d  = '0;
                    end
                end
            end
            LOCKED: begin
                // Prediction advances regardless of the sample so glitches are ridden through.
                idx_d = succ(idx_q);
                if (one_hot && (hot_idx == idx_d)) begin
                    miss_d = '0;
                end else begin
                    bad   = 1'b1;
                    err_d = 1'b1;
                    if (miss_q == EW'(ERR_LIMIT - 1)) begin
                        state_d = SEARCH;
                        match_d = '0;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_q + 1'b1;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase

        // Clear takes effect before the count of the same cycle.
        cnt_base = clrErr ? 8'd0 : cnt_q;
        cnt_d    = (bad && (cnt_base != 8'hFF)) ? cnt_base + 8'd1 : cnt_base;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= SEARCH;
            idx_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            match_q <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            miss_q  <= miss_d;
        end
    end

    assign phaseIdx   = idx_q;
    assign phaseValid = valid_q;
    assign locked     = (state_q == LOCKED);
    assign phaseErr   = err_q;
    assign errCount   = cnt_q;

endmodule

// File: tb/tb_phase_tracker.sv
// Bench for phase_tracker: a 4-phase and a 2-phase instance driven in lockstep and
// compared every cycle against a behavioural model of the tracking rules.
module tb_phase_tracker;

    logic       clk;
    logic       rstN;
    logic [3:0] phase_in4;
    logic [1:0] phase_in2;
    logic       clr4, clr2;

    logic [1:0] idx4;
    logic       idx2;
    logic       valid4, valid2, locked4, locked2, err4, err2;
    logic [7:0] cnt4, cnt2;

    int checks = 0;
    int errors = 0;

    // model state, index 0 = 4-phase instance, index 1 = 2-phase instance
    int m_n[2]     = '{4, 2};
    int m_lockc[2] = '{4, 3};
    int m_lim[2]   = '{2, 3};
    bit m_locked[2];
    int m_idx[2];
    bit m_valid[2];
    bit m_err[2];
    int m_cnt[2];
    int m_match[2];
    int m_miss[2];

    int pos4, pos2;

    phase_tracker #(.PHASES(4), .LOCK_COUNT(4), .ERR_LIMIT(2)) dut4 (
        .clk(clk), .rstN(rstN), .phaseIn(phase_in4), .clrErr(clr4),
        .phaseIdx(idx4), .phaseValid(valid4), .locked(locked4),
        .phaseErr(err4), .errCount(cnt4)
    );

    phase_tracker #(.PHASES(2), .LOCK_COUNT(3), .ERR_LIMIT(3)) dut2 (
        .clk(clk), .rstN(rstN), .phaseIn(phase_in2), .clrErr(clr2),
        .phaseIdx(idx2), .phaseValid(valid2), .locked(locked2),
        .phaseErr(err2), .errCount(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nxt(int p, int n);
        return (p == 0) ? n - 1 : p - 1;
    endfunction

    function automatic logic [3:0] oh4(int p);
        logic [3:0] v;
        v = 4'd1 << p;
        return v;
    endfunction

    function automatic logic [1:0] oh2(int p);
        logic [1:0] v;
        v = 2'd1 << p;
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_locked[d] = 0; m_idx[d] = 0; m_valid[d] = 0; m_err[d] = 0;
            m_cnt[d] = 0; m_match[d] = 0; m_miss[d] = 0;
        end
    endtask

    task automatic model_step(int d, logic [3:0] v, bit clr);
        int ones, j, expect_idx;
        bit oh, bad;
        ones = 0; j = 0; bad = 0;
        for (int b = 0; b < m_n[d]; b++) if (v[b]) begin ones++; j = b; end
        oh = (ones == 1);
        if (m_locked[d]) begin
            expect_idx = nxt(m_idx[d], m_n[d]);
            m_idx[d] = expect_idx;
            if (oh && j == expect_idx) begin
                m_miss[d] = 0;
            end else begin
                bad = 1;
                m_miss[d]++;
                if (m_miss[d] >= m_lim[d]) begin
                    m_locked[d] = 0; m_match[d] = 0; m_miss[d] = 0;
                end
            end
        end else if (!oh) begin
            m_match[d] = 0;
        end else begin
            if (m_valid[d] && j == nxt(m_idx[d], m_n[d])) m_match[d]++;
            else m_match[d] = 1;
            m_idx[d] = j;
            if (m_match[d] >= m_lockc[d]) begin
                m_locked[d] = 1; m_miss[d] = 0;
            end
        end
        if (clr) m_cnt[d] = 0;
        if (bad && m_cnt[d] < 255) m_cnt[d]++;
        m_err[d] = bad;
        m_valid[d] = oh;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_all();
        chk("p4_idx",    32'(idx4),    32'(m_idx[0]));
        chk("p4_valid",  32'(valid4),  32'(m_valid[0]));
        chk("p4_locked", 32'(locked4), 32'(m_locked[0]));
        chk("p4_err",    32'(err4),    32'(m_err[0]));
        chk("p4_count",  32'(cnt4),    32'(m_cnt[0]));
        chk("p2_idx",    32'(idx2),    32'(m_idx[1]));
        chk("p2_valid",  32'(valid2),  32'(m_valid[1]));
        chk("p2_locked", 32'(locked2), 32'(m_locked[1]));
        chk("p2_err",    32'(err2),    32'(m_err[1]));
        chk("p2_count",  32'(cnt2),    32'(m_cnt[1]));
    endtask

    // One clock: drive both instances, advance the model, compare just after the edge.
    task automatic tick(logic [3:0] v4, bit c4, logic [1:0] v2, bit c2);
        phase_in4 = v4; clr4 = c4; phase_in2 = v2; clr2 = c2;
        @(posedge clk);
        #1;
        model_step(0, v4, c4);
        model_step(1, {2'b00, v2}, c2);
        check_all();
        pos4 = nxt(pos4, 4);
        pos2 = nxt(pos2, 2);
    endtask

    task automatic clean_ticks(int k);
        for (int i = 0; i < k; i++) tick(oh4(pos4), 0, oh2(pos2), 0);
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        rstN = 1'b1; phase_in4 = '0; phase_in2 = '0; clr4 = 0; clr2 = 0;
        pos4 = 0; pos2 = 0;
        #2;
        do_reset();

        // clean rotation 0001, 1000, 0100, 0010, ...: locks after the 4th edge
        pos4 = 0; pos2 = 0;
        clean_ticks(6);
        chk("lock_after_clean", 32'(locked4), 32'd1);

        // single dropout in place of 0100: flywheel keeps lock
        tick(4'b0000, 0, oh2(pos2), 0);
        chk("flywheel_idx", 32'(idx4), 32'd2);
        clean_ticks(3);

        // two consecutive bad samples force loss of lock, then re-lock
        tick(4'b1100, 0, oh2(pos2), 0);
        tick(4'b0000, 0, oh2(pos2), 0);
        chk("unlocked_after_two_bad", 32'(locked4), 32'd0);
        clean_ticks(6);

        // constant 0010 never locks
        do_reset();
        for (int i = 0; i < 8; i++) tick(4'b0010, 0, 2'b10, 0);
        chk("static_no_lock", 32'(locked4), 32'd0);

        // alternating good/bad until the counter saturates
        clean_ticks(6);
        for (int i = 0; i < 260; i++) begin
            tick(4'b0000, 0, 2'b11, 0);
            clean_ticks(1);
        end
        chk("saturated", 32'(cnt4), 32'd255);
        tick(4'b0000, 1, 2'b00, 1);
        chk("clear_with_error", 32'(cnt4), 32'd1);
        tick(oh4(pos4), 1, oh2(pos2), 1);
        chk("clear_clean", 32'(cnt4), 32'd0);

        // asynchronous reset mid-cycle while locked
        clean_ticks(4);
        #2;
        rstN = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rstN = 1'b1;
        clean_ticks(5);

        // randomized glitches and clears
        for (int i = 0; i < 400; i++) begin
            logic [3:0] v4;
            logic [1:0] v2;
            v4 = ($urandom_range(0, 7) == 0) ? 4'($urandom) : oh4(pos4);
            v2 = ($urandom_range(0, 7) == 0) ? 2'($urandom) : oh2(pos2);
            tick(v4, $urandom_range(0, 19) == 0, v2, $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
